// File: rtl/i2c_line_conditioner.sv
// i2c_line_conditioner
// Pad-side front end for an I2C peripheral. Both lines are synchronised and
// glitch-filtered, then SCL edges, START/STOP conditions and bus occupancy
// are derived. While the bus is busy, every SCL rise yields one framed bit
// sample (8 data bits MSB-first, then the ACK slot).
module i2c_line_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_f,
    output logic       sda_f,
    output logic       scl_rise,
    output logic       scl_fall,
    output logic       start_det,
    output logic       stop_det,
    output logic       bus_busy,
    output logic       bit_valid,
    output logic       bit_data,
    output logic [3:0] bit_index
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    // Line 0 is SCL, line 1 is SDA.
    logic [1:0] w_raw;
    logic [1:0] w_filt;
    logic [1:0] w_dly;

    assign w_raw = {sda_in, scl_in};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_line
            logic [SYNC_STAGES-1:0] r_sync;
            logic [CW-1:0]          r_cnt;
            logic                   r_filt;
            logic                   r_dly;
            logic                   w_s;

            assign w_s        = r_sync[SYNC_STAGES-1];
            assign w_filt[gi] = r_filt;
            assign w_dly[gi]  = r_dly;

            // Synchronise the pad, then only accept a new level once it has
            // been seen FILTER_LEN cycles in a row; keep a one-cycle delayed
            // copy of the filtered level for edge detection.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync <= '1;
                    r_cnt  <= '0;
                    r_filt <= 1'b1;
                    r_dly  <= 1'b1;
                end else begin
                    r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[gi]};
                    r_dly  <= r_filt;
                    if (w_s == r_filt) begin
                        r_cnt <= '0;
                    end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
                        r_filt <= w_s;
                        r_cnt  <= '0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
            end
        end
    endgenerate

    logic w_scl_f, w_sda_f, w_scl_d, w_sda_d;
    logic w_scl_rise, w_scl_fall, w_start, w_stop;

    assign w_scl_f = w_filt[0];
    assign w_sda_f = w_filt[1];
    assign w_scl_d = w_dly[0];
    assign w_sda_d = w_dly[1];

    // SDA moving while SCL is steadily high marks START/STOP; if SCL also
    // moved this cycle, scl_d differs from scl_f and neither condition fires.
    assign w_scl_rise = w_scl_f & ~w_scl_d;
    assign w_scl_fall = ~w_scl_f & w_scl_d;
    assign w_start    = w_scl_f & w_scl_d & ~w_sda_f & w_sda_d;
    assign w_stop     = w_scl_f & w_scl_d & w_sda_f & ~w_sda_d;

    logic       r_bus_busy;
    logic [3:0] r_bit_cnt;
    logic       r_bit_valid;
    logic       r_bit_data;
    logic [3:0] r_bit_index;

    // Bus occupancy: set after START, cleared after STOP (a stray STOP while
    // idle simply leaves it low).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bus_busy <= 1'b0;
        end else if (w_start) begin
            r_bus_busy <= 1'b1;
        end else if (w_stop) begin
            r_bus_busy <= 1'b0;
        end
    end

    // Bit framing: sample SDA on each SCL rise inside a transfer. START and
    // STOP restart the 0..8 position count; the sample registers keep their
    // last value so a downstream core can read them at leisure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt   <= 4'd0;
            r_bit_valid <= 1'b0;
            r_bit_data  <= 1'b0;
            r_bit_index <= 4'd0;
        end else begin
            r_bit_valid <= 1'b0;
            if (w_start || w_stop) begin
                r_bit_cnt <= 4'd0;
            end else if (w_scl_rise && r_bus_busy) begin
                r_bit_valid <= 1'b1;
                r_bit_data  <= w_sda_f;
                r_bit_index <= r_bit_cnt;
                r_bit_cnt   <= (r_bit_cnt == 4'd8) ? 4'd0 : r_bit_cnt + 4'd1;
            end
        end
    end

    assign scl_f     = w_scl_f;
    assign sda_f     = w_sda_f;
    assign scl_rise  = w_scl_rise;
    assign scl_fall  = w_scl_fall;
    assign start_det = w_start;
    assign stop_det  = w_stop;
    assign bus_busy  = r_bus_busy;
    assign bit_valid = r_bit_valid;
    assign bit_data  = r_bit_data;
    assign bit_index = r_bit_index;

endmodule

// File: tb/tb_i2c_line_conditioner.sv
// Testbench for i2c_line_conditioner: directed I2C sequences plus random line
// activity, every cycle compared with a window-based behavioural model.
module tb_i2c_line_conditioner;

    localparam int SYNC_STAGES = 2;
    localparam int FILTER_LEN  = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scl_in, sda_in;
    logic       scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
    logic       bus_busy, bit_valid, bit_data;
    logic [3:0] bit_index;

    i2c_line_conditioner #(.SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) dut (
        .clk(clk), .rst_n(rst_n), .scl_in(scl_in), .sda_in(sda_in),
        .scl_f(scl_f), .sda_f(sda_f), .scl_rise(scl_rise), .scl_fall(scl_fall),
        .start_det(start_det), .stop_det(stop_det), .bus_busy(bus_busy),
        .bit_valid(bit_valid), .bit_data(bit_data), .bit_index(bit_index)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // ---------------- behavioural model ----------------
    // Raw samples are delayed SYNC_STAGES-1 further edges; a filtered line
    // flips once its last FILTER_LEN synchronised samples all disagree with it.
    bit         m_dl_scl[$], m_dl_sda[$];
    bit         m_win_scl[$], m_win_sda[$];
    bit         m_s_scl, m_s_sda, m_f_scl, m_f_sda, m_d_scl, m_d_sda;
    bit         m_busy, m_bv, m_bd;
    logic [3:0] m_bi;
    int         m_pos;

    task automatic model_reset();
        m_dl_scl = {}; m_dl_sda = {}; m_win_scl = {}; m_win_sda = {};
        for (int i = 0; i < SYNC_STAGES; i++) begin m_dl_scl.push_back(1'b1); m_dl_sda.push_back(1'b1); end
        for (int i = 0; i < FILTER_LEN; i++) begin m_win_scl.push_back(1'b1); m_win_sda.push_back(1'b1); end
        m_s_scl = 1; m_s_sda = 1; m_f_scl = 1; m_f_sda = 1; m_d_scl = 1; m_d_sda = 1;
        m_busy = 0; m_bv = 0; m_bd = 0; m_bi = 4'd0; m_pos = 0;
    endtask

    task automatic model_step(input bit raw_scl, input bit raw_sda);
        bit rise, start, stop, flip_scl, flip_sda;
        rise  = m_f_scl && !m_d_scl;
        start = m_f_scl && m_d_scl && !m_f_sda && m_d_sda;
        stop  = m_f_scl && m_d_scl && m_f_sda && !m_d_sda;
        m_bv = 0;
        if (start || stop) m_pos = 0;
        else if (rise && m_busy) begin
            m_bv = 1; m_bd = m_f_sda; m_bi = 4'(m_pos); m_pos = (m_pos + 1) % 9;
        end
        if (start) m_busy = 1; else if (stop) m_busy = 0;
        m_win_scl.push_back(m_s_scl); void'(m_win_scl.pop_front());
        m_win_sda.push_back(m_s_sda); void'(m_win_sda.pop_front());
        flip_scl = 1; flip_sda = 1;
        foreach (m_win_scl[i]) if (m_win_scl[i] == m_f_scl) flip_scl = 0;
        foreach (m_win_sda[i]) if (m_win_sda[i] == m_f_sda) flip_sda = 0;
        m_d_scl = m_f_scl; m_d_sda = m_f_sda;
        if (flip_scl) m_f_scl = !m_f_scl;
        if (flip_sda) m_f_sda = !m_f_sda;
        m_dl_scl.push_back(raw_scl); void'(m_dl_scl.pop_front()); m_s_scl = m_dl_scl[0];
        m_dl_sda.push_back(raw_sda); void'(m_dl_sda.pop_front()); m_s_sda = m_dl_sda[0];
    endtask

    function automatic logic [15:0] model_vec();
        return {3'b0, m_f_scl, m_f_sda, m_f_scl & ~m_d_scl, ~m_f_scl & m_d_scl,
                m_f_scl & m_d_scl & ~m_f_sda & m_d_sda, m_f_scl & m_d_scl & m_f_sda & ~m_d_sda,
                m_busy, m_bv, m_bd, m_bi};
    endfunction

    function automatic logic [15:0] dut_vec();
        return {3'b0, scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det,
                bus_busy, bit_valid, bit_data, bit_index};
    endfunction

    // ---------------- observation log ----------------
    bit         q_bd[$];
    logic [3:0] q_bi[$];
    int n_start, n_stop, n_rise, n_fall, n_sdaf_low, n_idle;

    task automatic clear_obs();
        q_bd = {}; q_bi = {};
        n_start = 0; n_stop = 0; n_rise = 0; n_fall = 0; n_sdaf_low = 0; n_idle = 0;
    endtask

    task automatic step(input bit scl, input bit sda);
        scl_in = scl; sda_in = sda;
        @(posedge clk); #1;
        model_step(scl, sda);
        check_val("cycle", dut_vec(), model_vec());
        if (bit_valid) begin q_bd.push_back(bit_data); q_bi.push_back(bit_index); end
        n_start += int'(start_det); n_stop += int'(stop_det);
        n_rise += int'(scl_rise); n_fall += int'(scl_fall);
        n_sdaf_low += int'(!sda_f); n_idle += int'(!bus_busy);
    endtask

    task automatic hold(input bit scl, input bit sda, input int n);
        for (int i = 0; i < n; i++) step(scl, sda);
    endtask

    task automatic send_start();
        hold(0, sda_in, 6); hold(0, 1, 6); hold(1, 1, 8); hold(1, 0, 8);
    endtask

    task automatic send_stop();
        hold(0, sda_in, 6); hold(0, 0, 6); hold(1, 0, 8); hold(1, 1, 8);
    endtask

    task automatic clock_bit(input bit b);
        hold(0, sda_in, 6); hold(0, b, 6); hold(1, b, 8);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [8:0] pat;
        int lat;
        pat = 9'b101001010;
        rst_n = 1'b0; scl_in = 1'b0; sda_in = 1'b0;
        clear_obs();

        // Reset values with both pads low
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        check_val("reset", dut_vec(), 16'h1800);
        #3 rst_n = 1'b1;

        // Release: both filtered lines fall after SYNC_STAGES+FILTER_LEN edges
        lat = 0;
        while (scl_f !== 1'b0 && lat < 20) begin step(0, 0); lat++; end
        check_val("rst_lat", 16'(lat), 16'd5);
        check_val("rst_lat_sda", {15'b0, sda_f}, 16'h0);
        hold(1, 1, 12);

        // Glitch rejection: 2-cycle SDA low, then 3-cycle SDA low
        clear_obs();
        hold(1, 0, 2); hold(1, 1, 12);
        check_val("glitch2_start", 16'(n_start), 16'd0);
        check_val("glitch2_sdaf", 16'(n_sdaf_low), 16'd0);
        clear_obs();
        hold(1, 0, 3); hold(1, 1, 12);
        check_val("glitch3_start", 16'(n_start), 16'd1);
        check_val("glitch3_sdaf", {15'b0, n_sdaf_low > 0}, 16'd1);

        // Byte 0xA5 + ACK 0
        send_start();
        clear_obs();
        for (int i = 0; i < 9; i++) clock_bit(pat[8-i]);
        check_val("byte_count", 16'(q_bd.size()), 16'd9);
        for (int i = 0; i < 9 && i < q_bd.size(); i++) begin
            check_val($sformatf("byte_data%0d", i), {15'b0, q_bd[i]}, {15'b0, pat[8-i]});
            check_val($sformatf("byte_idx%0d", i), {12'b0, q_bi[i]}, 16'(i));
        end
        clear_obs();
        clock_bit(1);
        check_val("wrap_count", 16'(q_bi.size()), 16'd1);
        if (q_bi.size() > 0) check_val("wrap_idx", {12'b0, q_bi[0]}, 16'd0);

        // STOP, then clocks while idle
        clear_obs();
        send_stop();
        check_val("stop_count", 16'(n_stop), 16'd1);
        check_val("stop_busy", {15'b0, bus_busy}, 16'd0);
        clear_obs();
        for (int i = 0; i < 3; i++) clock_bit(i[0]);
        check_val("idle_bits", 16'(q_bd.size()), 16'd0);

        // Repeated START after 3 bits
        send_start();
        for (int i = 0; i < 3; i++) clock_bit(pat[8-i]);
        clear_obs();
        send_start();
        check_val("rstart_count", 16'(n_start), 16'd1);
        check_val("rstart_busy", 16'(n_idle), 16'd0);
        clear_obs();
        clock_bit(0);
        check_val("rstart_bits", 16'(q_bi.size()), 16'd1);
        if (q_bi.size() > 0) check_val("rstart_idx", {12'b0, q_bi[0]}, 16'd0);
        send_stop();

        // Simultaneous SCL/SDA change
        clear_obs();
        hold(0, 0, 8); hold(1, 1, 8);
        check_val("simul_startstop", 16'(n_start + n_stop), 16'd0);
        check_val("simul_edges", 16'(n_fall * 16 + n_rise), 16'd17);

        // Asynchronous reset mid-byte
        send_start();
        clock_bit(1); clock_bit(1); clock_bit(0); clock_bit(1);
        #2 rst_n = 1'b0;
        #1 check_val("async_rst", dut_vec(), 16'h1800);
        #3 rst_n = 1'b1;
        model_reset();
        clear_obs();
        for (int i = 0; i < 4; i++) clock_bit(i[0]);
        check_val("post_rst_bits", 16'(q_bd.size()), 16'd0);
        send_start();
        clear_obs();
        clock_bit(1);
        check_val("post_rst_idx", {12'b0, (q_bi.size() == 1) ? q_bi[0] : 4'hF}, 16'd0);
        send_stop();

        // Random line activity
        for (int i = 0; i < 400; i++)
            hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(1, 6)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
